// File: rtl/register_file_scoreboard.sv
// Architectural register file with write-first bypass and a per-register
// pending-write scoreboard that tells decode when its operands are ready.
module register_file_scoreboard #(
    parameter int REG_NUM    = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int PEND_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] rs1Addr,
    input  logic [ADDR_WIDTH-1:0] rs2Addr,
    input  logic [ADDR_WIDTH-1:0] prevRdAddr,
    input  logic                  prevWEnable,
    input  logic [ADDR_WIDTH-1:0] rdAddr,
    input  logic [DATA_WIDTH-1:0] wData,
    input  logic                  wEnable,
    output logic [DATA_WIDTH-1:0] rs1Data,
    output logic [DATA_WIDTH-1:0] rs2Data,
    output logic                  rs1Ready,
    output logic                  rs2Ready
);

    localparam logic [PEND_WIDTH-1:0] PEND_MAX = {PEND_WIDTH{1'b1}};
    localparam logic [PEND_WIDTH-1:0] PEND_ONE = PEND_WIDTH'(1);

    logic [DATA_WIDTH-1:0] r_regs [REG_NUM];
    logic [PEND_WIDTH-1:0] r_pend [REG_NUM];

    function automatic logic [DATA_WIDTH-1:0] f_read(input logic [ADDR_WIDTH-1:0] addr);
        if (addr == '0)
            return '0;
        else if (wEnable && rdAddr == addr)
            return wData;
        else
            return r_regs[addr];
    endfunction

    // A register whose last outstanding write is on the write port this cycle
    // is ready, because the bypass delivers that value.
    function automatic logic f_ready(input logic [ADDR_WIDTH-1:0] addr);
        return (addr == '0) || (r_pend[addr] == '0) ||
               (r_pend[addr] == PEND_ONE && wEnable && rdAddr == addr);
    endfunction

    always_comb begin
        rs1Data  = f_read(rs1Addr);
        rs2Data  = f_read(rs2Addr);
        rs1Ready = f_ready(rs1Addr);
        rs2Ready = f_ready(rs2Addr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < REG_NUM; r++) begin
                r_regs[r] <= '0;
                r_pend[r] <= '0;
            end
        end else begin
            if (wEnable && rdAddr != '0)
                r_regs[rdAddr] <= wData;
            for (int r = 1; r < REG_NUM; r++) begin
                if (prevWEnable && prevRdAddr == ADDR_WIDTH'(r) &&
                    !(wEnable && rdAddr == ADDR_WIDTH'(r))) begin
                    assert (r_pend[r] != PEND_MAX);
                    if (r_pend[r] != PEND_MAX)
                        r_pend[r] <= r_pend[r] + PEND_ONE;
                end else if (wEnable && rdAddr == ADDR_WIDTH'(r) &&
                             !(prevWEnable && prevRdAddr == ADDR_WIDTH'(r))) begin
                    assert (r_pend[r] != '0);
                    if (r_pend[r] != '0)
                        r_pend[r] <= r_pend[r] - PEND_ONE;
                end
            end
        end
    end

endmodule

// File: doc/register_file_scoreboard.md
# register_file_scoreboard

Architectural integer register file with a per-register pending-write scoreboard: the responder side of the register-file interface used by decode, writeback and the pipeline controller. It serves combinational source reads with writeback bypass, commits writeback data at the clock edge, and counts in-flight writes per destination register so that `rs1Ready`/`rs2Ready` tell the controller when decode may consume operands. It sits between the decode stage (read ports, issue notification) and the writeback stage (write port).

## Interface
- `REG_NUM`, 32: number of architectural registers; register 0 is hardwired to zero.
- `ADDR_WIDTH`, 5: register address width; must satisfy 2^ADDR_WIDTH = REG_NUM.
- `DATA_WIDTH`, 32: register data width.
- `PEND_WIDTH`, 2: width of each pending counter, giving at most 2^PEND_WIDTH-1 outstanding writes per register.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `rs1Addr` in ADDR_WIDTH: source 1 address from decode.
- `rs2Addr` in ADDR_WIDTH: source 2 address from decode.
- `prevRdAddr` in ADDR_WIDTH: destination of the instruction decode issues this cycle.
- `prevWEnable` in 1: the issued instruction writes `prevRdAddr`.
- `rdAddr` in ADDR_WIDTH: writeback destination.
- `wData` in DATA_WIDTH: writeback data.
- `wEnable` in 1: writeback valid.
- `rs1Data` out DATA_WIDTH: source 1 operand.
- `rs2Data` out DATA_WIDTH: source 2 operand.
- `rs1Ready` out 1: source 1 has no outstanding write, or its last outstanding write is being bypassed this cycle.
- `rs2Ready` out 1: same for source 2.

## Operation
- Storage: `regs[REG_NUM]`, plus counters `pend[REG_NUM]` of PEND_WIDTH bits each. `regs[0]` and `pend[0]` are always 0; writes and issues to address 0 are ignored.
- Read (combinational, per port X):
  - If `rsXAddr == 0`, `rsXData = 0`.
  - Else if `wEnable && rdAddr == rsXAddr`, `rsXData = wData` (write-first bypass).
  - Else `rsXData = regs[rsXAddr]`.
- Write: at the edge, if `wEnable && rdAddr != 0` and not `rst`, then `regs[rdAddr] <= wData`.
- Scoreboard update at the edge, evaluated per register r != 0:
  - `inc = prevWEnable && prevRdAddr == r`.
  - `dec = wEnable && rdAddr == r`.
  - `inc && !dec`: increment; saturate at max and hold, which is a protocol violation and is flagged by a simulation assertion.
  - `dec && !inc`: decrement; hold at 0, which is also asserted as a violation.
  - Both or neither: hold.
- Ready (combinational, per port X): `rsXReady = (rsXAddr == 0) || pend[rsXAddr] == 0 || (pend[rsXAddr] == 1 && wEnable && rdAddr == rsXAddr)`.
- The issue of the current cycle (`prevWEnable`) does not affect readiness in the same cycle. The controller must never issue an instruction whose own sources are not ready.
- Reset: all `regs` and all `pend` are cleared. Writes and issues presented in a reset cycle are discarded. Reset mid-flight abandons all outstanding writes; the pipeline is flushed by the same `rst`.

## Timing
- Output values after reset: `rs1Data`/`rs2Data` = 0 (unless bypassed), `rs1Ready`/`rs2Ready` = 1.
- Read latency is 0 cycles (combinational from address and write port).
- A write at edge N is visible from the array in cycle N+1, and through the bypass in the same cycle.
- An issue at edge N makes the register not-ready from cycle N+1 until the cycle its matching writeback is presented. That writeback cycle is ready via the bypass.
- No combinational path from `prevRdAddr`/`prevWEnable` to any output.

## Test plan
- Reset, then read x5 and x0 -> `rs1Data` = 0, `rs2Data` = 0, both ready = 1.
- Write x3 = 0xDEADBEEF with `rs1Addr` = 3 in the same cycle -> `rs1Data` = 0xDEADBEEF (bypass); next cycle with `wEnable` = 0 -> still 0xDEADBEEF.
- Issue rd = 7 (`prevWEnable` = 1), then hold `rs2Addr` = 7 -> `rs2Ready` = 0 for each idle cycle; in the cycle wEnable/rd = 7/0x1234 is presented -> `rs2Ready` = 1 and `rs2Data` = 0x1234.
- Issue rd = 9 twice on consecutive edges, then write back once -> `rs1Ready` (`rs1Addr` = 9) stays 0 in that writeback cycle; on the second writeback it is 1.
- Issue rd = 4 and write back rd = 4 in the same cycle with `pend[4]` = 1 -> `pend[4]` stays 1, so `rs1Ready` = 0 next cycle. Write to x0 with 0xFFFFFFFF -> reads of x0 return 0, ready = 1.
- Issue rd = 6, assert `rst` for one cycle while presenting write x6 = 0x55 -> afterwards x6 reads 0 and `rs1Ready` = 1.
